// File: rtl/hamming_scrub_mem.sv
// Hamming(7,4) codeword store with a background scrub engine that corrects single-bit errors.
// Optional macro SCRUB_IRQ_EN adds an err_irq pulse output after each counted correction.
module hamming_scrub_mem #(
   parameter int ADDR_W         = 4,
   parameter int DEPTH          = 16,
   parameter int SCRUB_INTERVAL = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [6:0]        wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [6:0]        rd_data,
   output logic              rd_valid,
   input  logic              scrub_en,
   output logic              scrub_busy,
   output logic [15:0]       err_count,
   output logic [ADDR_W-1:0] last_err_addr
`ifdef SCRUB_IRQ_EN
   ,
   output logic              err_irq
`endif
);

   localparam int CNT_W = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCRUB_INTERVAL - 1);

   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_READ, S_CHECK, S_WRITE} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   ptr_q, ptr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [6:0]          word_q, word_d;
   logic [15:0]         err_count_q, err_count_d;
   logic [ADDR_W-1:0]   last_err_q, last_err_d;
   logic [6:0]          rd_data_q, rd_data_d;
   logic                rd_valid_q, rd_valid_d;
   logic [6:0]          mem_q [DEPTH];

   logic                host_access, wr_hit, scrub_we, mem_we;
   logic [2:0]          syn;
   logic [6:0]          fixed_word, mem_wdata;
   logic [ADDR_W-1:0]   mem_waddr;

`ifdef SCRUB_IRQ_EN
   logic                irq_q, irq_d;
   assign err_irq = irq_q;
`endif

   function automatic logic [2:0] syndrome(input logic [6:0] cw);
      syndrome = {^{cw[3], cw[4], cw[5], cw[6]},
                  ^{cw[1], cw[2], cw[5], cw[6]},
                  ^{cw[0], cw[2], cw[4], cw[6]}};
   endfunction

   assign host_access = wr_en | rd_en;
   assign wr_hit      = wr_en && (wr_addr == ptr_q);
   assign syn         = syndrome(word_q);
   assign fixed_word  = word_q ^ (7'd1 << (syn - 3'd1));

   // Host write always owns the port; scrub only writes when no host access is present.
   assign mem_we    = wr_en | scrub_we;
   assign mem_waddr = wr_en ? wr_addr : ptr_q;
   assign mem_wdata = wr_en ? wr_data : fixed_word;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         ptr_q       <= '0;
         cnt_q       <= '0;
         word_q      <= '0;
         err_count_q <= '0;
         last_err_q  <= '0;
         rd_data_q   <= '0;
         rd_valid_q  <= 1'b0;
`ifdef SCRUB_IRQ_EN
         irq_q       <= 1'b0;
`endif
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
         word_q      <= word_d;
         err_count_q <= err_count_d;
         last_err_q  <= last_err_d;
         rd_data_q   <= rd_data_d;
         rd_valid_q  <= rd_valid_d;
`ifdef SCRUB_IRQ_EN
         irq_q       <= irq_d;
`endif
         if (mem_we) mem_q[mem_waddr] <= mem_wdata;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (scrub_en) state_d = S_WAIT;
         S_WAIT: begin
            if (!scrub_en)              state_d = S_IDLE;
            else if (cnt_q == CNT_LAST) state_d = S_READ;
         end
         S_READ:  if (!host_access) state_d = S_CHECK;
         S_CHECK: begin
            if (wr_hit || syn == 3'd0) state_d = scrub_en ? S_WAIT : S_IDLE;
            else                       state_d = S_WRITE;
         end
         S_WRITE: if (wr_hit || !host_access) state_d = scrub_en ? S_WAIT : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      word_d      = word_q;
      err_count_d = err_count_q;
      last_err_d  = last_err_q;
      scrub_we    = 1'b0;
`ifdef SCRUB_IRQ_EN
      irq_d       = 1'b0;
`endif
      rd_valid_d  = rd_en;
      rd_data_d   = rd_en ? mem_q[rd_addr] : rd_data_q;
      scrub_busy  = !(state_q == S_IDLE || state_q == S_WAIT);
      case (state_q)
         S_IDLE: cnt_d = '0;
         S_WAIT: begin
            if (!scrub_en || cnt_q == CNT_LAST) cnt_d = '0;
            else                                cnt_d = cnt_q + CNT_W'(1);
         end
         S_READ: if (!host_access) word_d = mem_q[ptr_q];
         S_CHECK: if (wr_hit || syn == 3'd0) ptr_d = ptr_q + ADDR_W'(1);
         S_WRITE: begin
            // A host write to the scrubbed address supersedes the stale correction.
            if (wr_hit) begin
               ptr_d = ptr_q + ADDR_W'(1);
            end else if (!host_access) begin
               scrub_we    = 1'b1;
               ptr_d       = ptr_q + ADDR_W'(1);
               last_err_d  = ptr_q;
               if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
`ifdef SCRUB_IRQ_EN
               irq_d       = 1'b1;
`endif
            end
         end
         default: ;
      endcase
   end

   assign rd_data       = rd_data_q;
   assign rd_valid      = rd_valid_q;
   assign err_count     = err_count_q;
   assign last_err_addr = last_err_q;

endmodule

// File: doc/hamming_scrub_mem.md
Name: hamming_scrub_mem

Overview:
- Codeword store between the Hamming(7,4) encoder and decoder: holds 7-bit codewords from the encoder and returns them on read for the decoder.
- A background scrub engine walks every address, checks the syndrome, and writes back the corrected codeword when a single-bit error is found.
- This stops soft errors from accumulating into uncorrectable double errors.

Parameters:
- ADDR_W, 4, address width.
- DEPTH, 16, number of codeword entries; must equal 2**ADDR_W.
- SCRUB_INTERVAL, 64, idle cycles between scrub steps; minimum 1.

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  synchronous reset, active-high.
- wr_en  in  1  host write strobe.
- wr_addr  in  ADDR_W  host write address.
- wr_data  in  7  codeword from encoder.
- rd_en  in  1  host read strobe.
- rd_addr  in  ADDR_W  host read address.
- rd_data  out  7  raw stored codeword, to decoder.
- rd_valid  out  1  rd_data valid; 1-cycle pulse.
- scrub_en  in  1  enables the background scrub engine.
- scrub_busy  out  1  high while FSM is not in IDLE or WAIT.
- err_count  out  16  corrected-error count, saturating at 16'hFFFF.
- last_err_addr  out  ADDR_W  address of the most recent correction.

Behaviour:
- Codeword layout: bit i is Hamming position i+1.
  - cw[0]=p1, cw[1]=p2, cw[2]=d0, cw[3]=p4, cw[4]=d1, cw[5]=d2, cw[6]=d3.
- Syndrome: s1=^{cw[0],cw[2],cw[4],cw[6]}; s2=^{cw[1],cw[2],cw[5],cw[6]}; s4=^{cw[3],cw[4],cw[5],cw[6]}.
  - S={s4,s2,s1}; S!=0 means flip cw[S-1].
- Reset values:
  - all memory entries 7'b0 (a valid codeword);
  - rd_data=0, rd_valid=0, scrub_busy=0, err_count=0, last_err_addr=0;
  - scrub pointer=0, interval counter=0, FSM=IDLE.
- Host write: 1-cycle; entry updated at the clk edge where wr_en=1.
- Host read: latency 1. rd_data/rd_valid are registered the cycle after rd_en.
  - rd_valid is low in every cycle without a read issued on the preceding edge.
  - rd_data holds its last value while rd_valid is low.
- Host read and write to the same address in the same cycle: read returns the OLD contents.
- Port arbitration: one array access per cycle. Priority: host write > host read > scrub.
- FSM states:
  - IDLE: go to WAIT when scrub_en=1.
  - WAIT: interval counter counts up. When it reaches SCRUB_INTERVAL-1, clear it and go to READ.
  - READ: read entry[ptr] into an internal register when no host access is present this cycle; otherwise stay in READ. Then go to CHECK.
  - CHECK: compute syndrome. S==0: advance ptr, go to WAIT. S!=0: go to WRITE.
  - WRITE: write the corrected word to entry[ptr] when no host access is present; otherwise stay in WRITE. Then:
    - err_count += 1, saturating;
    - last_err_addr <= ptr;
    - advance ptr, go to WAIT.
- Coherency: a host write to ptr while the FSM is in CHECK or WRITE cancels the writeback.
  - No count update, no write; advance ptr, go to WAIT.
- ptr wraps from DEPTH-1 to 0.
- scrub_en deasserted:
  - in WAIT or IDLE: go to IDLE and clear the interval counter.
  - in READ/CHECK/WRITE: the current step completes, then go to IDLE.
  - ptr is retained.
- Double errors are miscorrected as single errors; this is a known limitation of Hamming(7,4), accepted, and not flagged.
- rst mid-scrub: FSM=IDLE immediately, memory cleared, counters cleared; no partial writeback.

Optional Feature:
- Macro: SCRUB_IRQ_EN.
- Defined:
  - adds output port err_irq (1 bit), reset 0;
  - err_irq pulses high exactly one cycle, the cycle after each counted correction;
  - no pulse on cancelled writebacks.
- Undefined: port absent; all other behaviour identical.

Test Plan:
- Reset, then rd_en at addr 3 -> rd_valid=1 next cycle, rd_data=7'b0000000, err_count=0.
- Write 7'b0000111 (data 4'b0001) to addr 2, read addr 2 -> rd_data=7'b0000111 one cycle later; scrub_en=1 for a full pass gives err_count=0.
- Write 7'b1110111 (data 4'b1111 with cw[3] flipped) to addr 5, SCRUB_INTERVAL=4, scrub_en=1 for 200 cycles -> read addr 5 returns 7'b1111111, err_count=1, last_err_addr=5; with SCRUB_IRQ_EN, err_irq pulses once.
- Corrupted word at addr 7; host write 7'b0000000 to addr 7 in the cycle the FSM is in CHECK -> entry reads 7'b0000000, err_count unchanged.
- Corrupted word at addr 1; hold rd_en every cycle during the scrub READ phase -> scrub stalls and scrub_busy stays 1; after rd_en drops, the correction completes and err_count=1.
- Assert rst while the FSM is in WRITE -> next cycle scrub_busy=0, err_count=0, all entries read 7'b0.
